// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the writable IF-stage instruction memory and its loader.
package instr_mem_loader_pkg;

  // Controller states: CLEAR sweeps the fill word through every entry,
  // READY serves load beats from the programming port.
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // addi x0,x0,0 -- the canonical RISC-V NOP used as the fill word
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // True when an address lies inside the populated part of the address space.
  function automatic logic below_depth(input logic [31:0] addr, input logic [31:0] depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/instr_mem_loader_ram.sv
// Storage array for the instruction memory: one write port and one read port
// whose data is registered, so reads have one cycle of latency.
module imem_ram_1w1r #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // Only the low bits are needed to index DEPTH entries; the owner never
  // presents an out-of-range address with we/re asserted.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;
  logic [IDX_W-1:0]  widx_s;
  logic [IDX_W-1:0]  ridx_s;
  logic              unused_addr_bits_s;

  assign widx_s             = waddr[IDX_W-1:0];
  assign ridx_s             = raddr[IDX_W-1:0];
  assign unused_addr_bits_s = ^{waddr, raddr};

  // Write port: the array itself is not reset, it is initialised by the owner's sweep
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[widx_s] <= wdata;
    end
  end

  // Read data captures the addressed word on a read request and holds otherwise
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[ridx_s];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read data register
  always_ff @(posedge clock) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Writable instruction memory for the IF stage. A programming port loads the
// program (explicit address or auto-incrementing pointer) behind a valid/ready
// handshake; a sweep fills every entry with the NOP word after reset or on
// request; the fetch port returns data one cycle after fetch_en with a
// write-first bypass for a load landing on the fetched address.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 10,
  parameter int                DEPTH       = 1024,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = DATA_W'(NOP_INSTR)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_req,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_auto,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              busy,
  output logic [ADDR_W:0]   load_count,
  output logic              addr_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_MAX   = {(ADDR_W+1){1'b1}};

  // Registered state
  state_e            state_q,          state_d;
  logic [ADDR_W-1:0] clr_ptr_q,        clr_ptr_d;
  logic [ADDR_W-1:0] auto_ptr_q,       auto_ptr_d;
  logic [ADDR_W:0]   load_count_q,     load_count_d;
  logic              addr_err_q,       addr_err_d;
  logic              fetch_valid_q,    fetch_valid_d;
  logic              fetch_src_ram_q,  fetch_src_ram_d;
  logic [DATA_W-1:0] fetch_hold_q,     fetch_hold_d;

  // Combinational signals
  logic              ld_ready_s;
  logic              ld_fire_s;
  logic [ADDR_W-1:0] ld_addr_s;
  logic              ld_in_range_s;
  logic              load_we_s;
  logic              fetch_in_range_s;
  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_waddr_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic              ram_re_s;
  logic [DATA_W-1:0] ram_rdata_s;

  imem_ram_1w1r #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clock (clock),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (ram_wdata_s),
    .re    (ram_re_s),
    .raddr (fetch_addr),
    .rdata (ram_rdata_s)
  );

  // Load handshake: a clear request in the same cycle refuses the beat
  always_comb begin
    ld_ready_s = (state_q == ST_READY) && !clear_req;
    ld_fire_s  = ld_valid && ld_ready_s;
    if (ld_auto) begin
      ld_addr_s = auto_ptr_q;
    end else begin
      ld_addr_s = ld_addr;
    end
    ld_in_range_s = below_depth(32'(ld_addr_s), 32'(DEPTH));
    load_we_s     = ld_fire_s && ld_in_range_s;
  end

  // Controller next state: fill sweep, load accounting and the RAM write-port mux
  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    auto_ptr_d   = auto_ptr_q;
    load_count_d = load_count_q;
    addr_err_d   = addr_err_q;
    ram_we_s     = 1'b0;
    ram_waddr_s  = clr_ptr_q;
    ram_wdata_s  = CLEAR_VALUE;
    case (state_q)
      ST_CLEAR: begin
        ram_we_s = 1'b1;
        if (clear_req) begin
          // A fresh request restarts the sweep from entry 0
          clr_ptr_d    = ADDR_ZERO;
          load_count_d = CNT_ZERO;
          auto_ptr_d   = ADDR_ZERO;
          addr_err_d   = 1'b0;
        end else if (clr_ptr_q == LAST_ADDR) begin
          clr_ptr_d = ADDR_ZERO;
          state_d   = ST_READY;
        end else begin
          clr_ptr_d = clr_ptr_q + ADDR_ONE;
        end
      end
      ST_READY: begin
        if (clear_req) begin
          state_d      = ST_CLEAR;
          clr_ptr_d    = ADDR_ZERO;
          load_count_d = CNT_ZERO;
          auto_ptr_d   = ADDR_ZERO;
          addr_err_d   = 1'b0;
        end else if (load_we_s) begin
          ram_we_s    = 1'b1;
          ram_waddr_s = ld_addr_s;
          ram_wdata_s = ld_data;
          if (load_count_q != CNT_MAX) begin
            load_count_d = load_count_q + CNT_ONE;
          end else begin
            load_count_d = load_count_q;
          end
          if (ld_addr_s == LAST_ADDR) begin
            auto_ptr_d = ADDR_ZERO;
          end else begin
            auto_ptr_d = ld_addr_s + ADDR_ONE;
          end
        end else if (ld_fire_s) begin
          // Accepted beat aimed beyond the populated entries: dropped, flagged
          addr_err_d = 1'b1;
        end else begin
          addr_err_d = addr_err_q;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_ptr_d = ADDR_ZERO;
      end
    endcase
  end

  // Fetch path: pick the source of next cycle's fetch_data
  always_comb begin
    fetch_valid_d    = fetch_en;
    fetch_src_ram_d  = fetch_src_ram_q;
    fetch_hold_d     = fetch_hold_q;
    ram_re_s         = 1'b0;
    fetch_in_range_s = below_depth(32'(fetch_addr), 32'(DEPTH));
    if (fetch_en) begin
      if ((state_q == ST_CLEAR) || !fetch_in_range_s) begin
        fetch_src_ram_d = 1'b0;
        fetch_hold_d    = CLEAR_VALUE;
      end else if (load_we_s && (ld_addr_s == fetch_addr)) begin
        // Write-first: the word being loaded this cycle is what the fetch sees
        fetch_src_ram_d = 1'b0;
        fetch_hold_d    = ld_data;
      end else begin
        fetch_src_ram_d = 1'b1;
        ram_re_s        = 1'b1;
      end
    end else begin
      // No request: both the RAM read register and the hold register keep their value
      fetch_src_ram_d = fetch_src_ram_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= ST_CLEAR;
      clr_ptr_q       <= ADDR_ZERO;
      auto_ptr_q      <= ADDR_ZERO;
      load_count_q    <= CNT_ZERO;
      addr_err_q      <= 1'b0;
      fetch_valid_q   <= 1'b0;
      fetch_src_ram_q <= 1'b0;
      fetch_hold_q    <= {DATA_W{1'b0}};
    end else begin
      state_q         <= state_d;
      clr_ptr_q       <= clr_ptr_d;
      auto_ptr_q      <= auto_ptr_d;
      load_count_q    <= load_count_d;
      addr_err_q      <= addr_err_d;
      fetch_valid_q   <= fetch_valid_d;
      fetch_src_ram_q <= fetch_src_ram_d;
      fetch_hold_q    <= fetch_hold_d;
    end
  end

  assign ld_ready    = ld_ready_s;
  assign busy        = (state_q == ST_CLEAR);
  assign load_count  = load_count_q;
  assign addr_err    = addr_err_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = fetch_src_ram_q ? ram_rdata_s : fetch_hold_q;

endmodule
